// File: rtl/izhikevich_step_scheduler.sv
// Steps NUM_NEURONS Izhikevich neurons by one Euler step. All arithmetic goes
// through one shared sign-magnitude multiply/add unit, sequenced by micro-op.
module izhikevich_step_scheduler #(
  parameter int N           = 32,
  parameter int Q           = 16,
  parameter int NUM_NEURONS = 4,
  localparam int IDXW       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic [N-1:0]             a,
  input  logic [N-1:0]             b,
  input  logic [N-1:0]             c,
  input  logic [N-1:0]             d,
  input  logic [N-1:0]             dt,
  input  logic [N*NUM_NEURONS-1:0] i_in,
  output logic [NUM_NEURONS-1:0]   spikes,
  input  logic [IDXW-1:0]          rd_idx,
  output logic [N-1:0]             rd_v,
  output logic [N-1:0]             rd_u
);

  localparam logic [N-1:0] K004  = N'(32'h0000_0A3D);
  localparam logic [N-1:0] K5    = N'(5 << Q);
  localparam logic [N-1:0] K140  = N'(140 << Q);
  localparam logic [N-1:0] VTH   = N'(30 << Q);
  localparam logic [N-1:0] V_RST = {1'b1, (N-1)'(65 << Q)};
  localparam logic [N-1:0] U_RST = {1'b1, (N-1)'(13 << Q)};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [3:0]      uop;
  logic [IDXW-1:0] k;
  logic [N-1:0]    v_mem [NUM_NEURONS];
  logic [N-1:0]    u_mem [NUM_NEURONS];
  logic [N-1:0]    pa, pb, pc, pd, pdt;
  logic [N-1:0]    wv, wu, wi;
  logic [N-1:0]    m, s, t, vn, un;
  logic [N-1:0]    alu_x, alu_y, alu_r;
  logic            alu_mul;
  logic            accept;
  logic            last;
  logic            spike_hit;

  function automatic logic [N-1:0] sm_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-2:0] mag;
    logic         sgn;
    if (x[N-1] == y[N-1]) begin
      mag = x[N-2:0] + y[N-2:0];
      sgn = x[N-1];
    end else if (x[N-2:0] >= y[N-2:0]) begin
      mag = x[N-2:0] - y[N-2:0];
      sgn = x[N-1];
    end else begin
      mag = y[N-2:0] - x[N-2:0];
      sgn = y[N-1];
    end
    return (mag == '0) ? '0 : {sgn, mag};
  endfunction

  function automatic logic [N-1:0] sm_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-3:0] p;
    logic [N-2:0]   mag;
    p   = {{(N-1){1'b0}}, x[N-2:0]} * {{(N-1){1'b0}}, y[N-2:0]};
    mag = p[Q +: N-1];
    return (mag == '0) ? '0 : {x[N-1] ^ y[N-1], mag};
  endfunction

  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign last      = (k == IDXW'(NUM_NEURONS - 1));
  assign spike_hit = !vn[N-1] && (vn[N-2:0] >= VTH[N-2:0]);
  assign busy      = (state == S_LOAD) || (state == S_EXEC) || (state == S_WRITE);
  assign done      = (state == S_DONE);

  assign rd_v = (int'(rd_idx) < NUM_NEURONS) ? v_mem[rd_idx] : '0;
  assign rd_u = (int'(rd_idx) < NUM_NEURONS) ? u_mem[rd_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_EXEC;
      S_EXEC:  if (uop == 4'd13) state_nx = S_WRITE;
      S_WRITE: state_nx = last ? S_DONE : S_LOAD;
      S_DONE:  state_nx = start ? S_LOAD : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand select for the shared unit; WRITE reuses it for the spike-reset u+d.
  always_comb begin
    alu_mul = 1'b0;
    alu_x   = wv;
    alu_y   = '0;
    if (state == S_WRITE) begin
      alu_x = un;
      alu_y = pd;
    end else begin
      case (uop)
        4'd0:  begin alu_mul = 1'b1; alu_x = wv; alu_y = wv;   end
        4'd1:  begin alu_mul = 1'b1; alu_x = m;  alu_y = K004; end
        4'd2:  begin alu_mul = 1'b1; alu_x = wv; alu_y = K5;   end
        4'd3:  begin alu_x = m;  alu_y = s;                       end
        4'd4:  begin alu_x = s;  alu_y = K140;                    end
        4'd5:  begin alu_x = s;  alu_y = {~wu[N-1], wu[N-2:0]};   end
        4'd6:  begin alu_x = s;  alu_y = wi;                      end
        4'd7:  begin alu_mul = 1'b1; alu_x = s;  alu_y = pdt;  end
        4'd8:  begin alu_x = wv; alu_y = s;                       end
        4'd9:  begin alu_mul = 1'b1; alu_x = pb; alu_y = wv;   end
        4'd10: begin alu_x = t;  alu_y = {~wu[N-1], wu[N-2:0]};   end
        4'd11: begin alu_mul = 1'b1; alu_x = t;  alu_y = pa;   end
        4'd12: begin alu_mul = 1'b1; alu_x = t;  alu_y = pdt;  end
        4'd13: begin alu_x = wu; alu_y = t;                       end
        default: ;
      endcase
    end
    alu_r = alu_mul ? sm_mul(alu_x, alu_y) : sm_add(alu_x, alu_y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        v_mem[i] <= V_RST;
        u_mem[i] <= U_RST;
      end
      spikes <= '0;
      k      <= '0;
      uop    <= '0;
      pa     <= '0;
      pb     <= '0;
      pc     <= '0;
      pd     <= '0;
      pdt    <= '0;
      wv     <= '0;
      wu     <= '0;
      wi     <= '0;
      m      <= '0;
      s      <= '0;
      t      <= '0;
      vn     <= '0;
      un     <= '0;
    end else begin
      if (accept) begin
        pa     <= a;
        pb     <= b;
        pc     <= (c[N-2:0] == '0) ? '0 : c;
        pd     <= d;
        pdt    <= dt;
        spikes <= '0;
        k      <= '0;
      end
      case (state)
        S_LOAD: begin
          wv  <= v_mem[k];
          wu  <= u_mem[k];
          wi  <= i_in[k*N +: N];
          uop <= '0;
        end
        S_EXEC: begin
          uop <= uop + 4'd1;
          case (uop)
            4'd0, 4'd1:                      m  <= alu_r;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: s <= alu_r;
            4'd8:                            vn <= alu_r;
            4'd9, 4'd10, 4'd11, 4'd12:       t  <= alu_r;
            4'd13:                           un <= alu_r;
            default: ;
          endcase
        end
        S_WRITE: begin
          if (spike_hit) begin
            v_mem[k]  <= pc;
            u_mem[k]  <= alu_r;
            spikes[k] <= 1'b1;
          end else begin
            v_mem[k] <= vn;
            u_mem[k] <= un;
          end
          k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_izhikevich_step_scheduler.sv
// Scoreboard bench: stimulus queues expected step results, a monitor checks
// them on each done pulse.
module tb_izhikevich_step_scheduler;

  localparam int N  = 32;
  localparam int NN = 4;

  localparam logic [N-1:0] P_A    = 32'h0000_051E;
  localparam logic [N-1:0] P_B    = 32'h0000_3333;
  localparam logic [N-1:0] P_C    = 32'h8041_0000;
  localparam logic [N-1:0] P_D    = 32'h0008_0000;
  localparam logic [N-1:0] P_DT   = 32'h0001_0000;
  localparam logic [N-1:0] I100   = 32'h0064_0000;
  localparam logic [N-1:0] V_RST  = 32'h8041_0000;
  localparam logic [N-1:0] U_RST  = 32'h800D_0000;
  localparam logic [N-1:0] V_SUB  = 32'h8044_0743;
  localparam logic [N-1:0] U_SUB  = 32'h800D_0000;
  localparam logic [N-1:0] U_SPK  = 32'h8005_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy, done;
  logic [N-1:0]    a = '0, b = '0, c = '0, d = '0, dt = '0;
  logic [N*NN-1:0] i_in = '0;
  logic [NN-1:0]   spikes;
  logic [1:0]      rd_idx = '0;
  logic [N-1:0]    rd_v, rd_u;

  izhikevich_step_scheduler #(.N(N), .Q(16), .NUM_NEURONS(NN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .a(a), .b(b), .c(c), .d(d), .dt(dt), .i_in(i_in), .spikes(spikes),
    .rd_idx(rd_idx), .rd_v(rd_v), .rd_u(rd_u)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NN-1:0] spk;
    logic [N-1:0]  v [NN];
    logic [N-1:0]  u [NN];
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0, done_cnt = 0, busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Monitor: counts busy cycles and checks every completed step.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            check("done_without_expectation", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("done_cycle", cyc, e.cyc);
            check("busy_cycles", busy_cnt, 16 * NN);
            check("busy_at_done", busy, 1'b0);
            check("spikes", spikes, e.spk);
            for (int i = 0; i < NN; i++) begin
              rd_idx = 2'(i);
              #1;
              check($sformatf("v[%0d]", i), rd_v, e.v[i]);
              check($sformatf("u[%0d]", i), rd_u, e.u[i]);
            end
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic check_reset();
    for (int i = 0; i < NN; i++) begin
      rd_idx = 2'(i);
      #1;
      check($sformatf("rst_v[%0d]", i), rd_v, V_RST);
      check($sformatf("rst_u[%0d]", i), rd_u, U_RST);
    end
    check("rst_spikes", spikes, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_step(input logic [N*NN-1:0] iv, input exp_t e,
                          input bit stray_start, input bit abort);
    int target;
    int w;
    @(negedge clk);
    target = done_cnt + 1;
    a = P_A; b = P_B; c = P_C; d = P_D; dt = P_DT; i_in = iv;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.cyc = cyc + 16 * NN;
    exp_q.push_back(e);
    check("busy_after_start", busy, 1'b1);
    @(negedge clk);
    start = 1'b0;
    // Parameters changed mid-step must not affect the result.
    a = 32'h0001_0000; b = '0; c = '0; d = '0; dt = 32'h0002_0000;
    if (stray_start) begin
      repeat (28) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (abort) begin
      repeat (18) @(negedge clk);
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("no_done_after_abort", done_cnt, target - 1);
      return;
    end
    w = 0;
    while (done_cnt < target && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (done_cnt < target) void'(exp_q.pop_back());
    check("done_seen", done_cnt, target);
    repeat (80) @(negedge clk);
    check("single_done", done_cnt, target);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset();

    // Sub-threshold on all neurons, with a stray start mid-step.
    e.spk = '0;
    for (int i = 0; i < NN; i++) begin
      e.v[i] = V_SUB;
      e.u[i] = U_SUB;
    end
    run_step('0, e, 1'b1, 1'b0);

    // All neurons driven above threshold.
    do_reset();
    e.spk = 4'b1111;
    for (int i = 0; i < NN; i++) begin
      e.v[i] = V_RST;
      e.u[i] = U_SPK;
    end
    run_step({I100, I100, I100, I100}, e, 1'b0, 1'b0);

    // Per-neuron isolation.
    do_reset();
    e.spk = 4'b1010;
    e.v[0] = V_SUB; e.u[0] = U_SUB;
    e.v[1] = V_RST; e.u[1] = U_SPK;
    e.v[2] = V_SUB; e.u[2] = U_SUB;
    e.v[3] = V_RST; e.u[3] = U_SPK;
    run_step({I100, 32'h0, I100, 32'h0}, e, 1'b0, 1'b0);

    // Reset mid-step, then a normal step.
    do_reset();
    run_step({I100, 32'h0, I100, 32'h0}, e, 1'b0, 1'b1);
    check_reset();
    run_step({I100, 32'h0, I100, 32'h0}, e, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d expected_checks_done", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/izhikevich_step_scheduler.md
# izhikevich_step_scheduler

Time-multiplexed controller that advances NUM_NEURONS Izhikevich neurons by one Euler step. It reuses a single shared sign-magnitude fixed-point multiplier and adder from the core's arithmetic library, stepping through a fixed micro-op sequence per neuron. It holds per-neuron v/u state registers, latches configuration parameters at start, and reports spikes. It sits between the network-level timestep controller and the arithmetic datapath.

## Interface
- N, 32, word width; sign-magnitude: bit N-1 is sign, N-2:0 is magnitude
- Q, 16, fractional bits
- NUM_NEURONS, 4, neurons scheduled per step (1..64)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request one timestep; honoured only when busy=0
- busy  out  1  high while a step is in progress
- done  out  1  one-cycle pulse when a step completes
- a, b, c, d, dt  in  N each  model parameters and timestep, sampled on accepted start
- i_in  in  N*NUM_NEURONS  packed input currents; neuron k uses bits [k*N +: N]
- spikes  out  NUM_NEURONS  spike flag per neuron for the last completed step
- rd_idx  in  $clog2(NUM_NEURONS) (min 1)  state read index
- rd_v, rd_u  out  N each  combinational read of v[rd_idx], u[rd_idx]

## Operation
- Arithmetic:
  - Mult: sign = sa^sb; magnitude = (|a|*|b|)>>Q, truncated to N-1 bits.
  - Add: sign-magnitude add.
  - Any result with zero magnitude is written as all-zero. Negative zero is never stored.
- Constants: K004 = 0x00000A3D, K5 = 0x00050000, K140 = 0x008C0000, VTH = 30.0 = 0x001E0000.
- Reset values: v[k] = -65.0 (0x80410000), u[k] = -13.0 (0x800D0000), spikes = 0, busy = 0, done = 0, FSM = IDLE.
- States: IDLE -> LOAD -> EXEC (uop 0..13) -> WRITE -> LOAD for the next neuron, or DONE after the last neuron -> IDLE.
- IDLE: start=1 latches a, b, c, d, dt, clears spikes, sets neuron index to 0, and moves to LOAD. start while busy is ignored.
- LOAD: copies v[k], u[k] and the i_in slice into working registers.
- EXEC: one shared-unit op per cycle (m, s, t are temporaries):
  - 0: m = v*v
  - 1: m = m*K004
  - 2: s = v*K5
  - 3: s = m+s
  - 4: s = s+K140
  - 5: s = s+(-u)
  - 6: s = s+I
  - 7: s = s*dt
  - 8: vn = v+s
  - 9: t = b*v
  - 10: t = t+(-u)
  - 11: t = t*a
  - 12: t = t*dt
  - 13: un = u+t
- WRITE: compares vn against VTH using signed compare.
  - If vn >= VTH: v[k] = c, u[k] = un+d, spikes[k] = 1.
  - Otherwise: v[k] = vn, u[k] = un.
  - Then increments k.
- DONE: done=1 and busy=0 in this cycle; spikes are stable until the next accepted start.
- Overflow is not detected. The magnitude wraps per add/mult truncation.

## Timing
- Accepted start at edge E: busy=1 from E+1 and LOAD for neuron 0 in cycle E+1.
- Per neuron: 1 LOAD + 14 EXEC + 1 WRITE = 16 cycles.
- done=1, busy=0 in cycle E+1+16*NUM_NEURONS. A new start is accepted in that cycle's following edge or later.
- The v[k]/u[k] update is visible on rd_v/rd_u the cycle after that neuron's WRITE.
- i_in slice k is sampled only at that neuron's LOAD edge.
- Parameter changes during busy have no effect on the current step.
- rst_n low at any time, including mid-EXEC: all registers return to reset values immediately, with no done pulse.
- start held high continuously: a step is re-accepted on the first edge after DONE.

## Test plan
- Reset: after rst_n release, rd_v=0x80410000, rd_u=0x800D0000 for all idx, spikes=0, busy=0.
- Sub-threshold step, NUM_NEURONS=1, a=0x051E (0.02), b=0x3333 (0.2), c=0x80410000, d=0x00080000, dt=0x00010000, I=0 -> v=0x80440743, u=0x800D0000, spikes=0.
- Same config with I=0x00640000 (100.0) -> vn ≈ 31.97 >= 30, so v=0x80410000, u=0x80050000 (-5.0), spikes[0]=1.
- Latency, NUM_NEURONS=4, start at edge 0 -> busy high cycles 1..64, done pulse cycle 65 only. A start pulse at cycle 30 is ignored (exactly one done).
- Per-neuron isolation: I = {0, 100.0, 0, 100.0} -> spikes=4'b1010, and neurons 0/2 hold v=0x80440743.
- Reset mid-step: rst_n low at cycle 20 of a 4-neuron step -> state back to reset values, no done, and a subsequent start completes normally.
